// File: rtl/detection_overlay_if.sv
// Signal bundle between the pixel/detector sources and detection_overlay:
// incoming VGA pixel stream, Hough detector result, and the overlaid
// pixel stream plus committed-box status going back out.
interface detection_overlay_if;
    logic [9:0] vga_x;
    logic [8:0] vga_y;
    logic       pix_valid;
    logic [3:0] pixel_in;
    logic [9:0] det_x;
    logic [8:0] det_y;
    logic [3:0] det_score;
    logic [3:0] pixel_out;
    logic       out_valid;
    logic       overlay_on;
    logic [9:0] box_x;
    logic [8:0] box_y;
    logic       box_valid;
    logic [4:0] hold_cnt;

    modport master (
        output vga_x, vga_y, pix_valid, pixel_in, det_x, det_y, det_score,
        input  pixel_out, out_valid, overlay_on, box_x, box_y, box_valid, hold_cnt
    );

    modport slave (
        input  vga_x, vga_y, pix_valid, pixel_in, det_x, det_y, det_score,
        output pixel_out, out_valid, overlay_on, box_x, box_y, box_valid, hold_cnt
    );
endinterface

// File: rtl/detection_overlay.sv
// Keeps the best Hough detection of each frame, commits it at the frame
// boundary, holds it for a number of frames, and draws a square marker
// around the committed centre into the grey VGA pixel stream.
module detection_overlay #(
    parameter int         BOX_HALF    = 8,
    parameter int         MIN_SCORE   = 7,
    parameter int         HOLD_FRAMES = 30,
    parameter logic [3:0] MARK_LOCK   = 4'hF,
    parameter logic [3:0] MARK_COAST  = 4'h8
) (
    input logic           clk,
    input logic           rst_n,
    detection_overlay_if.slave bus
);

    localparam logic [3:0]  MIN_SCORE_L = 4'(MIN_SCORE);
    localparam logic [4:0]  HOLD_L      = 5'(HOLD_FRAMES);
    localparam logic [10:0] HALF_L      = 11'(BOX_HALF);

    typedef enum logic [1:0] {IDLE, LOCKED, COAST} state_t;

    state_t            state, state_next;
    logic [9:0]        box_x_r, box_x_next;
    logic [8:0]        box_y_r, box_y_next;
    logic [4:0]        hold_r, hold_next;

    logic              cand_valid;
    logic [9:0]        cand_x;
    logic [8:0]        cand_y;
    logic [3:0]        cand_score;

    logic              fb;
    logic              score_ok;
    logic              take_det;

    logic signed [10:0] dx, dy;
    logic [10:0]        adx, ady;
    logic               overlay_p0;
    logic [3:0]         pixel_p0;

    logic               vld_p1;
    logic               overlay_p1;
    logic [3:0]         pixel_p1;

    function automatic logic [10:0] mag(input logic signed [10:0] v);
        return v[10] ? $unsigned(-v) : $unsigned(v);
    endfunction

    assign fb       = bus.pix_valid && (bus.vga_x == 10'd0) && (bus.vga_y == 9'd0);
    assign score_ok = (bus.det_score >= MIN_SCORE_L);
    // At a frame boundary a qualifying detection starts the new frame's
    // candidate unconditionally; otherwise only a strictly better score wins.
    assign take_det = score_ok && (fb || !cand_valid || (bus.det_score > cand_score));

    // Candidate validity: cleared at reset and at each frame boundary unless
    // a qualifying detection arrives in that same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand_valid <= 1'b0;
        end else if (fb) begin
            cand_valid <= score_ok;
        end else if (take_det) begin
            cand_valid <= 1'b1;
        end
    end

    // Candidate payload; only meaningful while cand_valid is set.
    always_ff @(posedge clk) begin
        if (take_det) begin
            cand_x     <= bus.det_x;
            cand_y     <= bus.det_y;
            cand_score <= bus.det_score;
        end
    end

    // Commit/hold state, box and hold counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            box_x_r <= '0;
            box_y_r <= '0;
            hold_r  <= '0;
        end else begin
            state   <= state_next;
            box_x_r <= box_x_next;
            box_y_r <= box_y_next;
            hold_r  <= hold_next;
        end
    end

    // Frame-boundary commit decision; box only moves at fb, using the
    // candidate gathered before this cycle.
    always_comb begin
        state_next = state;
        box_x_next = box_x_r;
        box_y_next = box_y_r;
        hold_next  = hold_r;
        if (fb) begin
            if (cand_valid) begin
                state_next = LOCKED;
                box_x_next = cand_x;
                box_y_next = cand_y;
                hold_next  = HOLD_L;
            end else if (state != IDLE) begin
                if (hold_r > 5'd1) begin
                    state_next = COAST;
                    hold_next  = hold_r - 5'd1;
                end else begin
                    state_next = IDLE;
                    hold_next  = 5'd0;
                end
            end
        end
    end

    // Marker geometry against the box being committed at this edge, so the
    // fb pixel already sees the new box; signed offsets clip at screen edges.
    always_comb begin
        dx = $signed({1'b0, bus.vga_x}) - $signed({1'b0, box_x_next});
        dy = $signed({2'b0, bus.vga_y}) - $signed({2'b0, box_y_next});
        adx = mag(dx);
        ady = mag(dy);
        overlay_p0 = bus.pix_valid && (state_next != IDLE)
                     && (adx <= HALF_L) && (ady <= HALF_L)
                     && ((adx == HALF_L) || (ady == HALF_L)
                         || ((adx == 11'd0) && (ady == 11'd0)));
        pixel_p0 = 4'd0;
        if (bus.pix_valid) begin
            if (overlay_p0) begin
                pixel_p0 = (state_next == LOCKED) ? MARK_LOCK : MARK_COAST;
            end else begin
                pixel_p0 = bus.pixel_in;
            end
        end
    end

    // ---- stage p0 -> p1: registered pixel output ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1     <= 1'b0;
            overlay_p1 <= 1'b0;
            pixel_p1   <= 4'd0;
        end else begin
            vld_p1     <= bus.pix_valid;
            overlay_p1 <= overlay_p0;
            pixel_p1   <= pixel_p0;
        end
    end

    assign bus.pixel_out  = pixel_p1;
    assign bus.out_valid  = vld_p1;
    assign bus.overlay_on = overlay_p1;
    assign bus.box_x      = box_x_r;
    assign bus.box_y      = box_y_r;
    assign bus.box_valid  = (state != IDLE);
    assign bus.hold_cnt   = hold_r;

endmodule

// File: tb/tb_detection_overlay.sv
// Bench for detection_overlay: two instances (hold 30 and hold 3) share one
// stimulus; directed table, hand sequences, then random traffic against a
// frame-level reference model.
module tb_detection_overlay;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] vga_x = '0;
    logic [8:0] vga_y = '0;
    logic       pix_valid = 1'b0;
    logic [3:0] pixel_in = '0;
    logic [9:0] det_x = '0;
    logic [8:0] det_y = '0;
    logic [3:0] det_score = '0;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    detection_overlay_if if0();
    detection_overlay_if if1();

    assign if0.vga_x = vga_x;     assign if1.vga_x = vga_x;
    assign if0.vga_y = vga_y;     assign if1.vga_y = vga_y;
    assign if0.pix_valid = pix_valid; assign if1.pix_valid = pix_valid;
    assign if0.pixel_in = pixel_in;   assign if1.pixel_in = pixel_in;
    assign if0.det_x = det_x;     assign if1.det_x = det_x;
    assign if0.det_y = det_y;     assign if1.det_y = det_y;
    assign if0.det_score = det_score; assign if1.det_score = det_score;

    detection_overlay #(.HOLD_FRAMES(30)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    detection_overlay #(.HOLD_FRAMES(3))  dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

    int a_pix[2], a_vld[2], a_ov[2], a_bx[2], a_by[2], a_bv[2], a_hold[2];
    always_comb begin
        a_pix[0] = int'(if0.pixel_out);  a_pix[1] = int'(if1.pixel_out);
        a_vld[0] = int'(if0.out_valid);  a_vld[1] = int'(if1.out_valid);
        a_ov[0]  = int'(if0.overlay_on); a_ov[1]  = int'(if1.overlay_on);
        a_bx[0]  = int'(if0.box_x);      a_bx[1]  = int'(if1.box_x);
        a_by[0]  = int'(if0.box_y);      a_by[1]  = int'(if1.box_y);
        a_bv[0]  = int'(if0.box_valid);  a_bv[1]  = int'(if1.box_valid);
        a_hold[0] = int'(if0.hold_cnt);  a_hold[1] = int'(if1.hold_cnt);
    end

    // Reference model: per-frame best candidate; a box is alive while its
    // hold count is non-zero and is LOCKED only in the frame right after a commit.
    int m_hold[2], m_bx[2], m_by[2], m_cx[2], m_cy[2], m_cs[2];
    bit m_cv[2];
    int e_pix[2], e_vld[2], e_ov[2];

    function automatic int hold_of(input int k);
        return (k == 0) ? 30 : 3;
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_hold[k] = 0; m_bx[k] = 0; m_by[k] = 0;
            m_cv[k] = 0; m_cx[k] = 0; m_cy[k] = 0; m_cs[k] = 0;
            e_pix[k] = 0; e_vld[k] = 0; e_ov[k] = 0;
        end
    endtask

    task automatic model_clock();
        bit fb;
        int ds, adx, ady, mx;
        fb = pix_valid && vga_x == 0 && vga_y == 0;
        ds = int'(det_score);
        for (int k = 0; k < 2; k++) begin
            if (fb) begin
                if (m_cv[k]) begin
                    m_bx[k] = m_cx[k]; m_by[k] = m_cy[k]; m_hold[k] = hold_of(k);
                end else if (m_hold[k] > 0) begin
                    m_hold[k] = m_hold[k] - 1;
                end
                m_cv[k] = 0;
            end
            if (ds >= 7 && (!m_cv[k] || ds > m_cs[k])) begin
                m_cv[k] = 1; m_cx[k] = int'(det_x); m_cy[k] = int'(det_y); m_cs[k] = ds;
            end
            adx = iabs(int'(vga_x) - m_bx[k]);
            ady = iabs(int'(vga_y) - m_by[k]);
            mx = (adx > ady) ? adx : ady;
            e_vld[k] = pix_valid;
            e_ov[k] = (pix_valid && m_hold[k] > 0 && (mx == 8 || mx == 0)) ? 1 : 0;
            if (!pix_valid) e_pix[k] = 0;
            else if (e_ov[k] == 1) e_pix[k] = (m_hold[k] == hold_of(k)) ? 15 : 8;
            else e_pix[k] = int'(pixel_in);
        end
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_model(input int k);
        chk($sformatf("m%0d.pixel_out", k), a_pix[k], e_pix[k]);
        chk($sformatf("m%0d.out_valid", k), a_vld[k], e_vld[k]);
        chk($sformatf("m%0d.overlay_on", k), a_ov[k], e_ov[k]);
        chk($sformatf("m%0d.box_x", k), a_bx[k], m_bx[k]);
        chk($sformatf("m%0d.box_y", k), a_by[k], m_by[k]);
        chk($sformatf("m%0d.box_valid", k), a_bv[k], (m_hold[k] > 0) ? 1 : 0);
        chk($sformatf("m%0d.hold_cnt", k), a_hold[k], m_hold[k]);
    endtask

    // One clock with the given inputs; returns #1 after the edge.
    task automatic cyc(input int x, input int y, input bit pv, input int pin,
                       input int dxx, input int dyy, input int ds);
        vga_x = 10'(x); vga_y = 9'(y); pix_valid = pv; pixel_in = 4'(pin);
        det_x = 10'(dxx); det_y = 9'(dyy); det_score = 4'(ds);
        @(posedge clk);
        model_clock();
        #1;
    endtask

    typedef struct {
        int x, y; bit pv; int pin; int dxx, dyy, ds;
        int e_pix, e_ov, e_bx, e_by, e_bv, e_hold;
    } vec_t;

    function automatic vec_t v(input int x, input int y, input bit pv, input int pin,
                               input int dxx, input int dyy, input int ds,
                               input int ep, input int eo, input int ebx, input int eby,
                               input int ebv, input int eh);
        vec_t r;
        r.x = x; r.y = y; r.pv = pv; r.pin = pin; r.dxx = dxx; r.dyy = dyy; r.ds = ds;
        r.e_pix = ep; r.e_ov = eo; r.e_bx = ebx; r.e_by = eby; r.e_bv = ebv; r.e_hold = eh;
        return r;
    endfunction

    initial begin
        vec_t tbl[$];
        int x, y, ds;

        //           x    y   pv pin  detx dety sc   pix ov  bx   by  bv hold
        tbl.push_back(v(5,   5,   1, 3,  200, 150, 7,   3, 0,  0,   0,  0, 0));
        tbl.push_back(v(6,   5,   1, 3,  200, 150, 9,   3, 0,  0,   0,  0, 0));
        tbl.push_back(v(7,   5,   1, 3,  300, 100, 9,   3, 0,  0,   0,  0, 0));
        tbl.push_back(v(0,   0,   1, 2,  0,   0,   0,   2, 0,  200, 150, 1, 30));
        tbl.push_back(v(192, 150, 1, 1,  0,   0,   0,  15, 1,  200, 150, 1, 30));
        tbl.push_back(v(193, 151, 1, 5,  0,   0,   0,   5, 0,  200, 150, 1, 30));
        tbl.push_back(v(200, 150, 1, 5,  0,   0,   0,  15, 1,  200, 150, 1, 30));
        tbl.push_back(v(208, 142, 1, 0,  0,   0,   0,  15, 1,  200, 150, 1, 30));
        tbl.push_back(v(200, 160, 1, 6,  0,   0,   0,   6, 0,  200, 150, 1, 30));
        tbl.push_back(v(192, 150, 0, 9,  0,   0,   0,   0, 0,  200, 150, 1, 30));
        tbl.push_back(v(1,   1,   1, 4,  10,  10,  6,   4, 0,  200, 150, 1, 30));
        tbl.push_back(v(0,   0,   1, 4,  0,   0,   0,   4, 0,  200, 150, 1, 29));
        tbl.push_back(v(192, 150, 1, 1,  0,   0,   0,   8, 1,  200, 150, 1, 29));
        tbl.push_back(v(1,   1,   1, 4,  10,  10,  8,   4, 0,  200, 150, 1, 29));
        tbl.push_back(v(1,   2,   1, 4,  20,  20,  8,   4, 0,  200, 150, 1, 29));
        tbl.push_back(v(0,   0,   1, 4,  0,   0,   0,   4, 0,  10,  10,  1, 30));
        tbl.push_back(v(2,   2,   1, 3,  0,   0,   0,  15, 1,  10,  10,  1, 30));
        tbl.push_back(v(18,  10,  1, 3,  0,   0,   0,  15, 1,  10,  10,  1, 30));
        tbl.push_back(v(1,   1,   1, 4,  3,   4,   9,   4, 0,  10,  10,  1, 30));
        tbl.push_back(v(0,   0,   1, 7,  0,   0,   0,   7, 0,  3,   4,   1, 30));
        tbl.push_back(v(635, 4,   1, 7,  0,   0,   0,   7, 0,  3,   4,   1, 30));
        tbl.push_back(v(0,   4,   1, 7,  0,   0,   0,   7, 0,  3,   4,   1, 30));
        tbl.push_back(v(11,  4,   1, 7,  0,   0,   0,  15, 1,  3,   4,   1, 30));
        tbl.push_back(v(11,  12,  1, 2,  0,   0,   0,  15, 1,  3,   4,   1, 30));
        tbl.push_back(v(5,   0,   1, 2,  0,   0,   0,   2, 0,  3,   4,   1, 30));
        tbl.push_back(v(635, 479, 1, 2,  0,   0,   0,   2, 0,  3,   4,   1, 30));

        model_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.pixel_out", a_pix[0], 0);
        chk("reset.box_valid", a_bv[0], 0);
        chk("reset.hold_cnt", a_hold[0], 0);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            cyc(tbl[i].x, tbl[i].y, tbl[i].pv, tbl[i].pin, tbl[i].dxx, tbl[i].dyy, tbl[i].ds);
            chk($sformatf("vec%0d.pixel_out", i), a_pix[0], tbl[i].e_pix);
            chk($sformatf("vec%0d.overlay_on", i), a_ov[0], tbl[i].e_ov);
            chk($sformatf("vec%0d.out_valid", i), a_vld[0], tbl[i].pv ? 1 : 0);
            chk($sformatf("vec%0d.box_x", i), a_bx[0], tbl[i].e_bx);
            chk($sformatf("vec%0d.box_y", i), a_by[0], tbl[i].e_by);
            chk($sformatf("vec%0d.box_valid", i), a_bv[0], tbl[i].e_bv);
            chk($sformatf("vec%0d.hold_cnt", i), a_hold[0], tbl[i].e_hold);
        end

        // Simultaneous fb and detection: old candidate commits, new one next frame.
        cyc(1, 1, 1, 0, 40, 40, 9);
        cyc(0, 0, 1, 0, 50, 60, 9);
        chk("simul.box_x0", a_bx[0], 40);
        chk("simul.box_y0", a_by[0], 40);
        cyc(1, 1, 1, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0, 0);
        chk("simul.box_x1", a_bx[0], 50);
        chk("simul.box_y1", a_by[0], 60);
        chk("simul.hold", a_hold[0], 30);

        // Coast and expiry on the hold-3 instance.
        chk("coast.hold3", a_hold[1], 3);
        for (int f = 2; f >= 0; f--) begin
            cyc(0, 0, 1, 1, 0, 0, 0);
            chk($sformatf("coast.hold%0d", f), a_hold[1], f);
            chk($sformatf("coast.bv%0d", f), a_bv[1], (f > 0) ? 1 : 0);
            cyc(42, 60, 1, 3, 0, 0, 0);
            chk($sformatf("coast.pix%0d", f), a_pix[1], (f > 0) ? 8 : 3);
            chk($sformatf("coast.ov%0d", f), a_ov[1], (f > 0) ? 1 : 0);
        end
        chk("coast.inst0_hold", a_hold[0], 27);

        // Asynchronous reset mid-stream with a live box and a pending candidate.
        cyc(1, 1, 1, 5, 77, 77, 9);
        cyc(42, 60, 1, 5, 0, 0, 0);
        chk("prereset.box_valid", a_bv[0], 1);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async.pixel_out", a_pix[0], 0);
        chk("async.out_valid", a_vld[0], 0);
        chk("async.overlay_on", a_ov[0], 0);
        chk("async.box_x", a_bx[0], 0);
        chk("async.box_y", a_by[0], 0);
        chk("async.box_valid", a_bv[0], 0);
        chk("async.hold_cnt", a_hold[0], 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(3, 3, 1, 2, 0, 0, 0);
        cyc(0, 0, 1, 2, 0, 0, 0);
        cyc(5, 5, 1, 2, 0, 0, 0);
        chk("postreset.box_valid", a_bv[0], 0);
        chk("postreset.hold_cnt", a_hold[0], 0);
        chk_model(0);
        chk_model(1);

        // Random traffic against the reference model.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 19) == 0) begin
                x = 0; y = 0;
            end else if ($urandom_range(0, 1) == 0) begin
                x = m_bx[0] + int'($urandom_range(0, 18)) - 9;
                y = m_by[0] + int'($urandom_range(0, 18)) - 9;
                if (x < 0) x = 0;
                if (x > 639) x = 639;
                if (y < 0) y = 0;
                if (y > 479) y = 479;
            end else begin
                x = int'($urandom_range(0, 639));
                y = int'($urandom_range(0, 479));
            end
            ds = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : 0;
            cyc(x, y, ($urandom_range(0, 9) != 0), int'($urandom_range(0, 15)),
                int'($urandom_range(0, 639)), int'($urandom_range(0, 479)), ds);
            chk_model(0);
            chk_model(1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/detection_overlay.md
Name: detection_overlay

Overview:
- Consumer end of the Hough detector's result interface (detX/detY/score): accepts the per-cycle detection stream and keeps the best candidate per video frame.
- Commits that candidate at each frame boundary and holds it for a programmable number of frames.
- Draws a square marker around the committed centre into the outgoing 4-bit grey VGA pixel stream.
- Sits between the accumulator and the VGA output mux.

Parameters:
- BOX_HALF, 8: half-width of the square marker in pixels.
- MIN_SCORE, 7: minimum det_score accepted as a candidate.
- HOLD_FRAMES, 30: frames the marker persists after the last committed detection.
- MARK_LOCK, 4'hF: marker value in LOCKED.
- MARK_COAST, 4'h8: marker value in COAST.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: asynchronous active-low reset.
- vga_x, input, 10: current pixel column, 0..639.
- vga_y, input, 9: current pixel row, 0..479.
- pix_valid, input, 1: vga_x/vga_y/pixel_in valid this cycle.
- pixel_in, input, 4: incoming grey pixel.
- det_x, input, 10: detector centre X.
- det_y, input, 9: detector centre Y.
- det_score, input, 4: detector vote count; 0 means no detection.
- pixel_out, output, 4: pixel_in, or the marker value, registered.
- out_valid, output, 1: pix_valid delayed one cycle.
- overlay_on, output, 1: pixel_out carries marker this cycle.
- box_x, output, 10: committed centre X.
- box_y, output, 9: committed centre Y.
- box_valid, output, 1: a committed box exists (state != IDLE).
- hold_cnt, output, 5: remaining hold frames; HOLD_FRAMES must be ≤ 31.

Behaviour:
- Reset (rst_n low, asynchronous):
  - pixel_out, out_valid, overlay_on, box_x, box_y, box_valid, hold_cnt are all 0.
  - Candidate cleared; state IDLE.
  - Reset mid-frame takes effect immediately. The first frame boundary after release commits only detections seen after release.
- Frame boundary (fb): pix_valid && vga_x==0 && vga_y==0. Single-cycle event.
- Candidate capture, every cycle:
  - If det_score ≥ MIN_SCORE and (cand_valid==0 or det_score > cand_score): cand_x/cand_y/cand_score take det_x/det_y/det_score, and cand_valid becomes 1.
  - Ties keep the earlier candidate.
  - Capture is independent of pix_valid.
- Commit at fb, states IDLE / LOCKED / COAST:
  - cand_valid: box_x/box_y take the candidate, hold_cnt becomes HOLD_FRAMES, state goes to LOCKED from any state.
  - No cand_valid, state LOCKED or COAST with hold_cnt > 1: hold_cnt decrements, state goes to COAST.
  - No cand_valid, hold_cnt == 1: hold_cnt becomes 0, state goes to IDLE, box_valid falls.
  - No cand_valid, state IDLE: no change.
  - No fb: state, box and hold_cnt unchanged. The box never changes mid-frame.
- Simultaneous fb and qualifying detection:
  - The commit uses the old candidate.
  - The new detection becomes the first candidate of the new frame; cand_valid ends at 1.
  - Otherwise the candidate clears at fb.
- Drawing: one pipeline stage; pixel_out and out_valid are registered from this cycle's inputs.
  - dx = vga_x − box_x and dy = vga_y − box_y, computed as 11-bit signed. No wrap: a box near an edge is clipped, never mirrored.
  - overlay_on is set when all hold: pix_valid, box_valid, |dx| ≤ BOX_HALF, |dy| ≤ BOX_HALF, and at least one of: |dx|==BOX_HALF, |dy|==BOX_HALF, or dx==dy==0 (centre dot).
  - Overlay source is the box committed at this cycle's edge, so the fb pixel (0,0) already uses the new box.
  - pixel_out is MARK_LOCK (LOCKED) or MARK_COAST (COAST) when overlay_on, otherwise pixel_in.
  - When pix_valid is 0: out_valid 0, overlay_on 0, pixel_out 0.
- Latency: one clk from pixel_in to pixel_out; one clk from fb to the box_*/hold_cnt update.

Test Plan:
- Reset: hold rst_n low mid-stream with box_valid=1 → all outputs 0 asynchronously; after release a frame with no detections keeps box_valid=0.
- Lock: in frame N drive det (200,150) with scores 7 then 9, then det (300,100) score 9 → at the next fb box=(200,150), state LOCKED, hold_cnt=30. Pixel (192,150) gives pixel_out=4'hF; (193,151) passes through; (200,150) gives 4'hF.
- Threshold/tie: score 6 only → no commit. Scores 8 at (10,10) then 8 at (20,20) → commit (10,10).
- Coast/expire: HOLD_FRAMES=3, commit then empty frames → hold_cnt 2, 1, 0. Marker shows 4'h8 for two frames, then box_valid=0 with no marker.
- Edge clip: box at (3,4) → column 635 and rows above 0 never marked; (0,4) not marked; (11,4) marked.
- Simultaneous: det score 9 at (50,60) in the same cycle as fb, with the old candidate (40,40) → commit (40,40); the next fb commits (50,60).
